instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the LEGv8-style datapath.
- Fetches an instruction and latches it into the IR, classifies the opcode, and selects one per-class decoder, such as the CBZ/CBNZ decoder.
- Steps the 2-bit decoder `state` until that decoder returns `nextState` = 00, then refetches.
- Muxes the selected decoder's 31-bit control word and 64-bit K onto the datapath. Halts on illegal opcodes.

Parameters:
- NUM_CLASSES, 8, number of decoder slots. Fixed class map below; must be 8.
- FETCH_CW, 31'h0000_0006, control word driven during a fetch cycle. Increments PC by 4 and drives the instruction memory read.
- NOP_CW, 31'h0000_0000, control word with no register/RAM writes and all bus enables off.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  32  instruction memory read data.
- mem_ready  in  1  instruction memory data valid this cycle.
- cw_in  in  NUM_CLASSES*31  packed decoder control words; slot i = bits [i*31+30:i*31].
- ns_in  in  NUM_CLASSES*2  packed decoder nextState.
- k_in  in  NUM_CLASSES*64  packed decoder K.
- ir  out  32  latched instruction, fanned out to all decoders.
- state  out  2  decoder sub-state, fanned out to all decoders.
- control_word  out  31  to datapath.
- K  out  64  to datapath.
- ir_load  out  1  high in the cycle IR captures instr_in.
- exec_valid  out  1  high in EXEC cycles.
- halt  out  1  sticky, set by an illegal opcode.
- retired  out  32  retired-instruction count (optional feature).
- cycles  out  32  non-halted cycle count (optional feature).

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - Phase = FETCH; IR, state, class, halt, counters = 0.
  - Outputs: control_word = NOP_CW, K = 0, ir_load = 0, exec_valid = 0.
- Phases are FETCH, EXEC and HALT, encoded in a register separate from the 2-bit `state`.
- FETCH:
  - mem_ready = 0: control_word = NOP_CW, ir_load = 0, hold (wait indefinitely).
  - mem_ready = 1: control_word = FETCH_CW, ir_load = 1. At the clock edge, IR <= instr_in, class <= classify(instr_in), state <= 00.
    - Class 0: phase <= HALT.
    - Otherwise: phase <= EXEC.
- Classify, first match in this order:
  - 7 BR: instr[31:10] = 22'b1101011000011111000000
  - 1 CBZ/CBNZ: instr[31:25] = 7'b1011010
  - 2 B/BL: instr[30:26] = 5'b00101
  - 3 B.cond: instr[31:24] = 8'h54
  - 4 load/store: instr[27] = 1 and instr[25] = 0
  - 5 data-processing register: instr[27:25] = 3'b101
  - 6 data-processing immediate: instr[28:26] = 3'b100
  - no match: 0 (illegal)
- EXEC:
  - Outputs: exec_valid = 1, control_word = cw_in[class], K = k_in[class], state = current sub-state.
  - At the clock edge, n = ns_in[class]:
    - n = 00: phase <= FETCH, state <= 00, retired++.
    - Otherwise: state <= n.
- Runaway guard: if state = 11 and n ≠ 00, force FETCH (count as retired). Maximum EXEC length is therefore 4 cycles, even if a decoder loops.
- Single-cycle instructions take 2 cycles total: 1 fetch + 1 exec.
- HALT: halt = 1, control_word = NOP_CW, K = 0, state = 00. Only reset exits HALT; instr_in and mem_ready are ignored.
- Combinational paths: control_word and K are combinational from cw_in/k_in only in EXEC. ir and state are registered outputs, so the decoder→sequencer loop has no combinational cycle.
- Counters: both wrap at 2^32 with no saturation. cycles increments every non-HALT cycle after reset.

Optional Feature:
- INSTR_SEQ_PERF_EN defined: retired and cycles counters are implemented as above.
- Undefined: no counter flops; retired and cycles are tied to 0. All other behaviour is identical.

Test Plan:
- Reset held for 2 cycles with mem_ready = 1 → control_word = 0, ir = 0, state = 00, halt = 0. The first post-reset cycle shows ir_load = 1 and control_word = FETCH_CW.
- Fetch 32'hB400_0041 (CBZ), slot 1 ns = 00, cw_in slot 1 = 31'h1234_5678 → one EXEC cycle with control_word = 31'h1234_5678, state = 00, then FETCH. retired = 1 with the feature enabled.
- mem_ready low for 3 cycles in FETCH → control_word = NOP_CW, ir unchanged. Capture occurs on the first mem_ready = 1 cycle.
- Load/store 32'hF840_0020, slot 4 ns sequence 01→10→00 → state outputs 00, 01, 10 over 3 EXEC cycles, then FETCH.
- Decoder slot 5 ns stuck at 01, then 11 → state 00→01→11 (guard-forced), then FETCH after 3 EXEC cycles. Verify the 4-cycle cap with ns = 01, 10, 11, 11.
- Fetch 32'h0000_0000 → halt = 1 next cycle; control_word stays 0 for 10 cycles regardless of mem_ready. Asserting reset mid-halt clears halt and returns to FETCH.

Source files
------------

// File: rtl/instr_sequencer_if.sv
//------------------------------------------------------------------------------
// instr_sequencer_if : sequencer <-> memory/decoder/datapath signal bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_sequencer_if #(
  parameter int NUM_CLASSES = 8
);
  logic [31:0]               instr_in;
  logic                      mem_ready;
  logic [NUM_CLASSES*31-1:0] cw_in;
  logic [NUM_CLASSES*2-1:0]  ns_in;
  logic [NUM_CLASSES*64-1:0] k_in;
  logic [31:0]               ir;
  logic [1:0]                state;
  logic [30:0]               control_word;
  logic [63:0]               K;
  logic                      ir_load;
  logic                      exec_valid;
  logic                      halt;
  logic [31:0]               retired;
  logic [31:0]               cycles;

  modport master (
    input  instr_in, mem_ready, cw_in, ns_in, k_in,
    output ir, state, control_word, K, ir_load, exec_valid, halt, retired, cycles
  );

  modport slave (
    output instr_in, mem_ready, cw_in, ns_in, k_in,
    input  ir, state, control_word, K, ir_load, exec_valid, halt, retired, cycles
  );
endinterface

`default_nettype wire

// File: rtl/instr_sequencer.sv
//------------------------------------------------------------------------------
// instr_sequencer : multi-cycle LEGv8 control sequencer (fetch / per-class
//                   decoder stepping / halt). INSTR_SEQ_PERF_EN adds counters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_sequencer #(
  parameter int          NUM_CLASSES = 8,
  parameter logic [30:0] FETCH_CW    = 31'h0000_0006,
  parameter logic [30:0] NOP_CW      = 31'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  instr_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_EXEC  = 2'd1,
    PH_HALT  = 2'd2
  } phase_e;

  phase_e      phase_q;
  logic [31:0] ir_q;
  logic [1:0]  state_q;
  logic [2:0]  class_q;
  logic        halt_q;

  logic [30:0] w_cw_slot [NUM_CLASSES];
  logic [1:0]  w_ns_slot [NUM_CLASSES];
  logic [63:0] w_k_slot  [NUM_CLASSES];

  logic [2:0]  w_new_class;
  logic [1:0]  w_ns;
  logic        w_fetch_go;
  logic        w_in_exec;
  logic        w_retire;
  logic [30:0] w_cw;
  logic [63:0] w_k;

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_slot
    assign w_cw_slot[g] = bus.cw_in[g*31 +: 31];
    assign w_ns_slot[g] = bus.ns_in[g*2 +: 2];
    assign w_k_slot[g]  = bus.k_in[g*64 +: 64];
  end

  // Priority order matters: earlier patterns overlap later, broader ones.
  function automatic logic [2:0] classify(input logic [31:0] instr);
    logic [2:0] c;
    c = 3'd0;
    if (instr[31:10] == 22'b1101011000011111000000) c = 3'd7;
    else if (instr[31:25] == 7'b1011010)            c = 3'd1;
    else if (instr[30:26] == 5'b00101)              c = 3'd2;
    else if (instr[31:24] == 8'h54)                 c = 3'd3;
    else if (instr[27] && !instr[25])               c = 3'd4;
    else if (instr[27:25] == 3'b101)                c = 3'd5;
    else if (instr[28:26] == 3'b100)                c = 3'd6;
    return c;
  endfunction

  assign w_new_class = classify(bus.instr_in);
  assign w_ns        = w_ns_slot[class_q];
  assign w_fetch_go  = !reset && (phase_q == PH_FETCH) && bus.mem_ready;
  assign w_in_exec   = !reset && (phase_q == PH_EXEC);
  // Sub-state 11 is the last allowed step, bounding EXEC at 4 cycles.
  assign w_retire    = (w_ns == 2'b00) || (state_q == 2'b11);

  always_comb begin
    w_cw = NOP_CW;
    w_k  = 64'd0;
    if (w_fetch_go) begin
      w_cw = FETCH_CW;
    end else if (w_in_exec) begin
      w_cw = w_cw_slot[class_q];
      w_k  = w_k_slot[class_q];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= PH_FETCH;
      ir_q    <= 32'd0;
      state_q <= 2'b00;
      class_q <= 3'd0;
      halt_q  <= 1'b0;
    end else begin
      case (phase_q)
        PH_FETCH: begin
          if (bus.mem_ready) begin
            ir_q    <= bus.instr_in;
            class_q <= w_new_class;
            state_q <= 2'b00;
            if (w_new_class == 3'd0) begin
              phase_q <= PH_HALT;
              halt_q  <= 1'b1;
            end else begin
              phase_q <= PH_EXEC;
            end
          end
        end
        PH_EXEC: begin
          if (w_retire) begin
            phase_q <= PH_FETCH;
            state_q <= 2'b00;
          end else begin
            state_q <= w_ns;
          end
        end
        PH_HALT: begin
          phase_q <= PH_HALT;
        end
        default: begin
          phase_q <= PH_FETCH;
          state_q <= 2'b00;
        end
      endcase
    end
  end

`ifdef INSTR_SEQ_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] cycles_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= 32'd0;
      cycles_q  <= 32'd0;
    end else begin
      if ((phase_q == PH_EXEC) && w_retire) retired_q <= retired_q + 32'd1;
      if (phase_q != PH_HALT)               cycles_q  <= cycles_q + 32'd1;
    end
  end

  assign bus.retired = retired_q;
  assign bus.cycles  = cycles_q;
`else
  assign bus.retired = 32'd0;
  assign bus.cycles  = 32'd0;
`endif

  assign bus.ir           = ir_q;
  assign bus.state        = state_q;
  assign bus.halt         = halt_q;
  assign bus.ir_load      = w_fetch_go;
  assign bus.exec_valid   = w_in_exec;
  assign bus.control_word = w_cw;
  assign bus.K            = w_k;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
//------------------------------------------------------------------------------
// tb_instr_sequencer : vector table of instructions with emulated decoder
//                      nextState maps; EXEC outputs checked from a queue.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_sequencer;
  localparam int          NC       = 8;
  localparam logic [30:0] FETCH_CW = 31'h0000_0006;
  localparam logic [30:0] NOP_CW   = 31'h0000_0000;
  localparam int          NVEC     = 9;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  cls;     // expected class
    logic [7:0]  ns_map;  // decoder nextState indexed by current state
    int          len;     // expected EXEC cycles (0 = halt)
    logic [7:0]  states;  // expected state per EXEC cycle
    int          stall;   // mem_ready-low cycles before the fetch
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    logic [30:0] cw;
    logic [63:0] k;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0] cur_cls = 3'd0;
  logic [7:0] cur_map = 8'd0;
  int n_applied = 0;
  int n_miss    = 0;
  int exp_retired = 0;
  logic [30:0] cw_tab [NC];
  logic [63:0] k_tab  [NC];
  vec_t vecs [NVEC];
  exp_t sb [$];

  instr_sequencer_if #(.NUM_CLASSES(NC)) bus ();

  instr_sequencer #(.NUM_CLASSES(NC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Emulated decoders: only the expected slot follows the vector map.
  always_comb begin
    bus.ns_in = '0;
    for (int c = 0; c < NC; c++) begin
      if (c == int'(cur_cls)) bus.ns_in[c*2 +: 2] = cur_map[int'(bus.state)*2 +: 2];
      else                    bus.ns_in[c*2 +: 2] = 2'b01;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (bus.exec_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("exec_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("exec_state", 64'(bus.state), 64'(e.st));
        chk("exec_cw", 64'(bus.control_word), 64'(e.cw));
        chk("exec_k", bus.K, e.k);
      end
    end
  end

  // Entered and left right after a falling edge.
  task automatic run_vec(input int v);
    logic [31:0] ir_before;
    ir_before = bus.ir;
    cur_cls = vecs[v].cls;
    cur_map = vecs[v].ns_map;
    bus.instr_in  = vecs[v].instr;
    bus.mem_ready = 1'b0;
    for (int s = 0; s < vecs[v].stall; s++) begin
      @(negedge clock);
      chk("stall_cw", 64'(bus.control_word), 64'(NOP_CW));
      chk("stall_ir_load", 64'(bus.ir_load), 64'd0);
      chk("stall_ir", 64'(bus.ir), 64'(ir_before));
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("fetch_ir_load", 64'(bus.ir_load), 64'd1);
    chk("fetch_cw", 64'(bus.control_word), 64'(FETCH_CW));
    for (int j = 0; j < vecs[v].len; j++) begin
      exp_t e;
      e.st = vecs[v].states[j*2 +: 2];
      e.cw = cw_tab[vecs[v].cls];
      e.k  = k_tab[vecs[v].cls];
      sb.push_back(e);
    end
    @(posedge clock);
    #1 bus.mem_ready = 1'b0;
    repeat (vecs[v].len) @(posedge clock);
    @(negedge clock);
    if (vecs[v].len > 0) exp_retired++;
    chk("done_exec_valid", 64'(bus.exec_valid), 64'd0);
    chk("done_cw", 64'(bus.control_word), 64'(NOP_CW));
    chk("done_ir", 64'(bus.ir), 64'(vecs[v].instr));
    chk("done_state", 64'(bus.state), 64'd0);
    chk("done_halt", 64'(bus.halt), (vecs[v].len == 0) ? 64'd1 : 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
`ifdef INSTR_SEQ_PERF_EN
    chk("retired", 64'(bus.retired), 64'(exp_retired));
`else
    chk("retired_tied", 64'(bus.retired), 64'd0);
    chk("cycles_tied", 64'(bus.cycles), 64'd0);
`endif
  endtask

  initial begin
    logic [31:0] cyc_at_halt;
    cw_tab = '{31'h0AAA_0000, 31'h1234_5678, 31'h0222_2222, 31'h0333_3333,
               31'h0444_4444, 31'h0555_5555, 31'h0666_6666, 31'h0777_7777};
    for (int i = 0; i < NC; i++) begin
      k_tab[i] = {32'hCAFE_0000 + 32'(i), 32'hF00D_0000 + 32'(i)};
      bus.cw_in[i*31 +: 31] = cw_tab[i];
      bus.k_in[i*64 +: 64]  = k_tab[i];
    end
    //            instr         cls   ns_map{s3,s2,s1,s0}  len states{e3..e0} stall
    vecs[0] = '{32'hB400_0041, 3'd1, 8'b00_00_00_00, 1, 8'b00_00_00_00, 0};
    vecs[1] = '{32'hF840_0020, 3'd4, 8'b00_00_10_01, 3, 8'b00_10_01_00, 3};
    vecs[2] = '{32'h8B02_0020, 3'd5, 8'b01_01_11_01, 3, 8'b00_11_01_00, 0};
    vecs[3] = '{32'h9100_0420, 3'd6, 8'b11_11_10_01, 4, 8'b11_10_01_00, 1};
    vecs[4] = '{32'hD61F_03C0, 3'd7, 8'b00_00_00_00, 1, 8'b00_00_00_00, 0};
    vecs[5] = '{32'h1400_0010, 3'd2, 8'b00_00_00_10, 2, 8'b00_00_10_00, 0};
    vecs[6] = '{32'h5400_0040, 3'd3, 8'b00_00_00_11, 2, 8'b00_00_11_00, 2};
    vecs[7] = '{32'h9400_0010, 3'd2, 8'b00_00_00_00, 1, 8'b00_00_00_00, 0};
    vecs[8] = '{32'h0000_0000, 3'd0, 8'b00_00_00_00, 0, 8'b00_00_00_00, 0};

    bus.instr_in  = vecs[0].instr;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cw", 64'(bus.control_word), 64'd0);
    chk("rst_k", bus.K, 64'd0);
    chk("rst_ir", 64'(bus.ir), 64'd0);
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_halt", 64'(bus.halt), 64'd0);
    chk("rst_ir_load", 64'(bus.ir_load), 64'd0);
    chk("rst_exec_valid", 64'(bus.exec_valid), 64'd0);
    chk("rst_retired", 64'(bus.retired), 64'd0);
    chk("rst_cycles", 64'(bus.cycles), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ir_load", 64'(bus.ir_load), 64'd1);
    chk("post_rst_cw", 64'(bus.control_word), 64'(FETCH_CW));
    bus.mem_ready = 1'b0;
    @(negedge clock);

    for (int v = 0; v < NVEC; v++) run_vec(v);

    cyc_at_halt = bus.cycles;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      bus.instr_in  = $urandom();
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("halt_cw", 64'(bus.control_word), 64'd0);
      chk("halt_sticky", 64'(bus.halt), 64'd1);
      chk("halt_ir_load", 64'(bus.ir_load), 64'd0);
      chk("halt_k", bus.K, 64'd0);
    end
    chk("halt_cycles_frozen", 64'(bus.cycles), 64'(cyc_at_halt));

    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_halt_clear", 64'(bus.halt), 64'd0);
    chk("rst_halt_ir", 64'(bus.ir), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_retired = 0;
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end
endmodule

`default_nettype wire
